// File: rtl/modn_digit_counter.sv
// Parametrised modulo-N up/down digit for the stopwatch datapath, with
// clamped load, sticky range error, lap capture and a cascade flag.
module modn_digit_counter #(
    parameter int MODULUS = 6,
    parameter int WIDTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             lap,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] lap_q,
    output logic             lap_valid,
    output logic             flag,
    output logic             wrap,
    output logic             err
);
    localparam int              WIDTH_EXT = WIDTH + 1;
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT  = WIDTH_EXT'(MODULUS);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] lap_q_r;
    logic             lap_valid_r;
    logic             wrap_r;
    logic             err_r;

    logic [WIDTH-1:0] q_next_s;
    logic [WIDTH-1:0] lap_q_next_s;
    logic             lap_valid_next_s;
    logic             err_next_s;
    logic             terminal_s;
    logic             flag_s;

    // Next value of a free-running step, wrapping at both ends of the range.
    function automatic logic [WIDTH-1:0] count_step(input logic [WIDTH-1:0] cur,
                                                    input logic             dir_up);
        logic [WIDTH-1:0] nxt;
        if (dir_up) begin
            if (cur == MAX_VAL) nxt = {WIDTH{1'b0}};
            else                nxt = cur + WIDTH'(1'b1);
        end else begin
            if (cur == {WIDTH{1'b0}}) nxt = MAX_VAL;
            else                      nxt = cur - WIDTH'(1'b1);
        end
        return nxt;
    endfunction

    // Widened compare so MODULUS == 2**WIDTH never flags a load as out of range.
    function automatic logic load_in_range(input logic [WIDTH-1:0] v);
        return ({1'b0, v} < MOD_EXT);
    endfunction

    // Terminal count for the current direction.
    always_comb begin
        if (up) terminal_s = (q_r == MAX_VAL);
        else    terminal_s = (q_r == {WIDTH{1'b0}});
    end

    assign flag_s = enable & ~clear & ~load & terminal_s;

    // Next-state selection with clear > load > enable priority; lap is independent of load/enable.
    always_comb begin
        q_next_s         = q_r;
        lap_q_next_s     = lap_q_r;
        lap_valid_next_s = lap_valid_r;
        err_next_s       = err_r;
        if (clear) begin
            q_next_s         = {WIDTH{1'b0}};
            lap_q_next_s     = {WIDTH{1'b0}};
            lap_valid_next_s = 1'b0;
            err_next_s       = 1'b0;
        end else begin
            if (load) begin
                if (load_in_range(load_value)) begin
                    q_next_s = load_value;
                end else begin
                    q_next_s   = MAX_VAL;
                    err_next_s = 1'b1;
                end
            end else if (enable) begin
                q_next_s = count_step(q_r, up);
            end else begin
                q_next_s = q_r;
            end
            if (lap) begin
                lap_q_next_s     = q_r;
                lap_valid_next_s = 1'b1;
            end else begin
                lap_q_next_s     = lap_q_r;
                lap_valid_next_s = lap_valid_r;
            end
        end
    end

    // State registers; a wrap happens exactly on edges where flag is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r         <= {WIDTH{1'b0}};
            lap_q_r     <= {WIDTH{1'b0}};
            lap_valid_r <= 1'b0;
            wrap_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            q_r         <= q_next_s;
            lap_q_r     <= lap_q_next_s;
            lap_valid_r <= lap_valid_next_s;
            wrap_r      <= flag_s;
            err_r       <= err_next_s;
        end
    end

    assign q         = q_r;
    assign lap_q     = lap_q_r;
    assign lap_valid = lap_valid_r;
    assign wrap      = wrap_r;
    assign err       = err_r;
    assign flag      = flag_s;

endmodule

// File: tb/tb_modn_digit_counter.sv
// Directed self-checking bench: mod-6 digit behaviour plus a mod-10/mod-6 cascade.
module tb_modn_digit_counter;
    logic       clk;
    logic       reset;
    logic       enable, up, clear, load, lap;
    logic [3:0] load_value;
    logic [3:0] q, lap_q;
    logic       lap_valid, flag, wrap, err;

    logic       c_en;
    logic [3:0] u_q, u_lap_q, t_q, t_lap_q;
    logic       u_lap_valid, u_flag, u_wrap, u_err;
    logic       t_lap_valid, t_flag, t_wrap, t_err;

    int test_cnt;
    int fail_cnt;

    modn_digit_counter #(.MODULUS(6), .WIDTH(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear),
        .load(load), .load_value(load_value), .lap(lap), .q(q), .lap_q(lap_q),
        .lap_valid(lap_valid), .flag(flag), .wrap(wrap), .err(err)
    );

    modn_digit_counter #(.MODULUS(10), .WIDTH(4)) units (
        .clk(clk), .reset(reset), .enable(c_en), .up(1'b1), .clear(1'b0),
        .load(1'b0), .load_value(4'd0), .lap(1'b0), .q(u_q), .lap_q(u_lap_q),
        .lap_valid(u_lap_valid), .flag(u_flag), .wrap(u_wrap), .err(u_err)
    );

    modn_digit_counter #(.MODULUS(6), .WIDTH(4)) tens (
        .clk(clk), .reset(reset), .enable(u_flag), .up(1'b1), .clear(1'b0),
        .load(1'b0), .load_value(4'd0), .lap(1'b0), .q(t_q), .lap_q(t_lap_q),
        .lap_valid(t_lap_valid), .flag(t_flag), .wrap(t_wrap), .err(t_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int up_q   [7] = '{0, 1, 2, 3, 4, 5, 0};
        int up_fl  [7] = '{0, 0, 0, 0, 0, 1, 0};
        int up_wr  [7] = '{0, 0, 0, 0, 0, 0, 1};
        int dn_q   [7] = '{0, 5, 4, 3, 2, 1, 0};
        int dn_fl  [7] = '{1, 0, 0, 0, 0, 0, 1};
        int dn_wr  [7] = '{0, 1, 0, 0, 0, 0, 0};
        int t_wraps;
        int u_wraps;

        test_cnt = 0;
        fail_cnt = 0;
        reset = 1'b0;
        enable = 1'b0; up = 1'b0; clear = 1'b0; load = 1'b0; lap = 1'b0;
        load_value = 4'd0; c_en = 1'b0;

        // reset state, before any clock edge
        #2;
        check_val("rst_q", q, 0);
        check_val("rst_lap_q", lap_q, 0);
        check_val("rst_lap_valid", lap_valid, 0);
        check_val("rst_wrap", wrap, 0);
        check_val("rst_err", err, 0);
        check_val("rst_flag_idle", flag, 0);
        enable = 1'b1;
        #1;
        check_val("rst_flag_down_terminal", flag, 1);
        enable = 1'b0;
        up = 1'b1;
        reset = 1'b1;

        step();
        check_val("hold_q", q, 0);

        // count up through a full wrap
        enable = 1'b1;
        up = 1'b1;
        for (int k = 0; k < 7; k++) begin
            check_val($sformatf("up_q_%0d", k), q, up_q[k]);
            check_val($sformatf("up_flag_%0d", k), flag, up_fl[k]);
            check_val($sformatf("up_wrap_%0d", k), wrap, up_wr[k]);
            step();
        end

        // count down from reset
        reset = 1'b0;
        #1;
        reset = 1'b1;
        up = 1'b0;
        #1;
        for (int k = 0; k < 7; k++) begin
            check_val($sformatf("dn_q_%0d", k), q, dn_q[k]);
            check_val($sformatf("dn_flag_%0d", k), flag, dn_fl[k]);
            check_val($sformatf("dn_wrap_%0d", k), wrap, dn_wr[k]);
            step();
        end
        check_val("dn_end_q", q, 5);

        // load beats enable; out-of-range load clamps and sets sticky err
        up = 1'b1;
        load = 1'b1;
        load_value = 4'd3;
        #1;
        check_val("load_gates_flag", flag, 0);
        step();
        check_val("load3_q", q, 3);
        check_val("load3_wrap", wrap, 0);
        load_value = 4'd9;
        step();
        check_val("load9_q", q, 5);
        check_val("load9_err", err, 1);
        load_value = 4'd2;
        step();
        check_val("load2_q", q, 2);
        check_val("load2_err_sticky", err, 1);
        load = 1'b0;
        clear = 1'b1;
        step();
        check_val("clear_q", q, 0);
        check_val("clear_err", err, 0);

        // lap capture while counting continues
        clear = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check_val("pre_lap_q", q, 4);
        lap = 1'b1;
        step();
        lap = 1'b0;
        check_val("lap_q_live", q, 5);
        check_val("lap_q_val", lap_q, 4);
        check_val("lap_valid", lap_valid, 1);
        step();
        check_val("lap_hold_q", q, 0);
        check_val("lap_hold_val", lap_q, 4);
        lap = 1'b1;
        clear = 1'b1;
        step();
        lap = 1'b0;
        clear = 1'b0;
        check_val("lapclr_q", q, 0);
        check_val("lapclr_lap_q", lap_q, 0);
        check_val("lapclr_lap_valid", lap_valid, 0);

        // async reset mid-count with err, lap_valid set
        enable = 1'b0;
        load = 1'b1;
        load_value = 4'd9;
        lap = 1'b1;
        step();
        load = 1'b0;
        lap = 1'b0;
        check_val("pre_rst_err", err, 1);
        check_val("pre_rst_lap_valid", lap_valid, 1);
        enable = 1'b1;
        step();
        check_val("pre_rst_wrap", wrap, 1);
        for (int k = 0; k < 3; k++) step();
        check_val("pre_rst_q", q, 3);
        #2;
        reset = 1'b0;
        #1;
        check_val("async_q", q, 0);
        check_val("async_wrap", wrap, 0);
        check_val("async_err", err, 0);
        check_val("async_lap_valid", lap_valid, 0);
        reset = 1'b1;
        enable = 1'b0;

        // two-digit cascade, 60 ticks
        step();
        c_en = 1'b1;
        t_wraps = 0;
        u_wraps = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (t_wrap) t_wraps++;
            if (u_wrap) u_wraps++;
            if (k == 37) begin
                check_val("cas37_units", u_q, 7);
                check_val("cas37_tens", t_q, 3);
            end
        end
        c_en = 1'b0;
        check_val("cas60_units", u_q, 0);
        check_val("cas60_tens", t_q, 0);
        check_val("cas_tens_wraps", t_wraps, 1);
        check_val("cas_units_wraps", u_wraps, 6);
        check_val("cas_err", {30'd0, u_err, t_err}, 0);
        check_val("cas_lap", {22'd0, u_lap_valid, t_lap_valid, u_lap_q, t_lap_q}, 0);
        check_val("cas_tens_flag", t_flag, 0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end
endmodule

// File: doc/modn_digit_counter.md
# modn_digit_counter

Parametrised single-digit modulo-N counter for the stopwatch datapath, replacing the fixed mod-6 digit. It counts 0..MODULUS-1 up or down on an enable tick and supports synchronous clear and load, with out-of-range load detection. It also provides a lap capture register that freezes a displayed value while counting continues. Digits cascade by driving the next digit's `enable` from this digit's `flag`.

## Interface

- `MODULUS`, default 6: count range is 0..MODULUS-1; legal values 2..2^WIDTH.
- `WIDTH`, default 4: width of the count, load and lap buses; 2^WIDTH >= MODULUS is required.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `enable`  in  1  count tick; advances the count by one step per clock while high.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `clear`  in  1  synchronous clear of the count, lap and error state.
- `load`  in  1  synchronous load of `load_value`.
- `load_value`  in  WIDTH  value to load.
- `lap`  in  1  capture the current count into `lap_q`.
- `q`  out  WIDTH  live count.
- `lap_q`  out  WIDTH  captured lap value.
- `lap_valid`  out  1  high once a lap has been captured since the last clear or reset.
- `flag`  out  1  combinational cascade/terminal strobe.
- `wrap`  out  1  registered one-cycle pulse after a modulo wrap.
- `err`  out  1  sticky out-of-range-load indicator.

## Operation

- Per-edge priority: `clear` > `load` > `enable`. Lower-priority actions in the same cycle are ignored.
- Clear: `q`, `lap_q`, `lap_valid` and `err` go to 0. A `lap` in the same cycle is ignored.
- Load with `load_value` < MODULUS: `q` <= `load_value`.
- Load with `load_value` >= MODULUS: `q` <= MODULUS-1 (clamped) and `err` <= 1.
- `err` stays high until `clear` or reset. A subsequent in-range load does not clear it.
- Count up (`enable`=1, `up`=1): if `q` = MODULUS-1, `q` <= 0 and a wrap is recorded; otherwise `q` <= `q`+1.
- Count down (`enable`=1, `up`=0): if `q` = 0, `q` <= MODULUS-1 and a wrap is recorded; otherwise `q` <= `q`-1.
- `enable`=0 with no clear or load: `q` holds.
- `flag` = `enable` & ~`clear` & ~`load` & (`up` ? `q`=MODULUS-1 : `q`=0).
  - It is high exactly in the cycle whose edge wraps the digit.
  - Downstream digits use it as their `enable`.
- Lap (`clear`=0):
  - `lap_q` <= the pre-edge value of `q`, and `lap_valid` <= 1.
  - The capture works in any cycle, regardless of `enable` or `load`.
  - Repeated laps overwrite `lap_q`.
- Arithmetic is modulo MODULUS only. `q` never holds a value >= MODULUS.

## Timing

- Reset (`reset`=0): effective immediately, without waiting for a clock edge.
  - `q`=0, `lap_q`=0, `lap_valid`=0, `wrap`=0, `err`=0.
  - `flag` follows its combinational equation, so it is 0 unless `enable`=1 and the terminal condition holds with `up`=0.
- Reset deassertion is assumed synchronised upstream. The first count occurs at the first rising edge with `reset`=1.
- `q`, `lap_q`, `lap_valid` and `err` update at the rising edge where the action is sampled, giving one cycle of latency.
- `flag` has zero latency and is combinational from `enable`, `up`, `clear`, `load` and `q`.
- `wrap` is high for exactly one cycle, the cycle following the edge at which `q` wrapped.
  - A wrap on consecutive edges (MODULUS=2 with `enable` held) keeps `wrap` high continuously.
- `up` may change on any cycle. It applies from the next edge, with no extra latency.
- Reset asserted mid-count overrides everything. A pending wrap pulse is discarded.

## Test plan

- MODULUS=6, `up`=1, `enable` held for 7 clocks from reset:
  - `q` = 0,1,2,3,4,5,0.
  - `flag`=1 only while `q`=5.
  - `wrap`=1 only in the cycle after `q` returns to 0.
- MODULUS=6, `up`=0, `enable` held from reset:
  - `q` = 0,5,4,3,2,1,0.
  - `flag`=1 while `q`=0.
  - `wrap` pulses after each 0->5 transition.
- Load with `load_value`=3 and `enable`=1 in the same cycle: `q`=3, not 4. Then `load_value`=9: `q`=5, `err`=1. A further in-range load leaves `err`=1. `clear` gives `q`=0, `err`=0.
- Lap at `q`=4 while counting up:
  - `lap_q`=4 and `lap_valid`=1 next cycle, while `q`=5 and counting continues.
  - `lap` and `clear` asserted together: everything 0 and `lap_valid`=0.
- Two-digit cascade, MODULUS=10 (units) feeding MODULUS=6 (tens):
  - 60 enable ticks from reset return both digits to 0.
  - Tens `wrap` pulses once.
- Async reset pulsed low between edges at `q`=3: `q`=0 before the next edge. `wrap`, `err` and `lap_valid` read 0.
